// File: rtl/moving_average_pkg.sv
// moving_average_pkg: shared state encoding and width helpers for the moving-average accumulator
package moving_average_pkg;
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int sum_width(input int width, input int positions);
    return width + clog2(positions);
  endfunction
endpackage

// File: rtl/moving_average_accumulator_if.sv
// moving_average_accumulator_if: sample inputs and window results of the moving-average stage
// master drives clear/sample_in/sample_delayed and observes sum_out/avg_out/out_valid/filling;
// slave is the accumulator side.
interface moving_average_accumulator_if
  import moving_average_pkg::*;
#(
  parameter int POSITIONS = 8,
  parameter int WIDTH = 8
);
  localparam int SW = sum_width(WIDTH, POSITIONS);
  logic clear;
  logic [WIDTH-1:0] sample_in;
  logic [WIDTH-1:0] sample_delayed;
  logic [SW-1:0] sum_out;
  logic [WIDTH-1:0] avg_out;
  logic out_valid;
  logic filling;
  modport master(output clear, sample_in, sample_delayed, input sum_out, avg_out, out_valid, filling);
  modport slave(input clear, sample_in, sample_delayed, output sum_out, avg_out, out_valid, filling);
endinterface

// File: rtl/moving_average_accumulator.sv
// moving_average_accumulator: running-sum moving average over the last POSITIONS samples
// Ports: clk (rising edge), rst_n (async active-low), bus (slave): clear, sample_in,
// sample_delayed in; sum_out, avg_out, out_valid, filling out (all registered).
module moving_average_accumulator
  import moving_average_pkg::*;
#(
  parameter int POSITIONS = 8,
  parameter int WIDTH = 8,
  parameter int ROUND = 0
) (
  input logic clk,
  input logic rst_n,
  moving_average_accumulator_if.slave bus
);
  localparam int LP = clog2(POSITIONS);
  localparam int SW = sum_width(WIDTH, POSITIONS);
  localparam int CW = LP + 1;
  localparam logic [SW:0] BIAS = (SW+1)'(ROUND != 0 ? POSITIONS / 2 : 0);
  localparam logic [SW:0] AMAX = (SW+1)'((64'd1 << WIDTH) - 64'd1);
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [SW-1:0] sum, sum_nxt;
  logic [WIDTH-1:0] avg, avg_nxt;
  logic [SW:0] mean;
  // The outgoing sample is only subtracted once a full window has been accumulated,
  // so stale delay-line contents after reset or clear never reach the sum.
  always_comb begin
    sum_nxt = sum + SW'(bus.sample_in) - (state == RUN ? SW'(bus.sample_delayed) : '0);
    mean = ({1'b0, sum_nxt} + BIAS) >> LP;
    avg_nxt = mean > AMAX ? '1 : mean[WIDTH-1:0];
    state_nxt = (state == RUN || cnt == CW'(POSITIONS - 1)) ? RUN : FILL;
    cnt_nxt = state == RUN ? cnt : cnt + 1'b1;
    if (bus.clear) begin
      sum_nxt = '0;
      avg_nxt = '0;
      state_nxt = IDLE;
      cnt_nxt = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      sum <= '0;
      avg <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      sum <= sum_nxt;
      avg <= avg_nxt;
    end
  assign bus.sum_out = sum;
  assign bus.avg_out = avg;
  assign bus.out_valid = state == RUN;
  assign bus.filling = state == FILL;
endmodule

// File: tb/tb_moving_average_accumulator.sv
// tb_moving_average_accumulator: table-driven, hand-written and random checks against a window model
module tb_moving_average_accumulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic [7:0] sample_in = '0;
  logic [7:0] sample_delayed = '0;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] dl [8];
  int win [$];
  typedef struct {
    logic c;
    logic [7:0] x;
    int s;
    int a;
    logic v;
    logic f;
  } vec_t;
  vec_t tbl [$];

  always #5 clk = ~clk;

  moving_average_accumulator_if #(.POSITIONS(8), .WIDTH(8)) m0 ();
  moving_average_accumulator_if #(.POSITIONS(8), .WIDTH(8)) m1 ();
  assign m0.clear = clear;
  assign m0.sample_in = sample_in;
  assign m0.sample_delayed = sample_delayed;
  assign m1.clear = clear;
  assign m1.sample_in = sample_in;
  assign m1.sample_delayed = sample_delayed;

  moving_average_accumulator #(.POSITIONS(8), .WIDTH(8), .ROUND(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(m0.slave));
  moving_average_accumulator #(.POSITIONS(8), .WIDTH(8), .ROUND(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(m1.slave));

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    int s;
    s = 0;
    foreach (win[i]) s += win[i];
    chk("model sum", int'(m0.sum_out), s);
    chk("model avg trunc", int'(m0.avg_out), s / 8);
    chk("model avg round", int'(m1.avg_out), ((s + 4) / 8 > 255) ? 255 : (s + 4) / 8);
    chk("model valid", int'(m0.out_valid), int'(win.size() == 8));
    chk("model filling", int'(m0.filling), int'(win.size() > 0 && win.size() < 8));
    chk("round dut sum", int'(m1.sum_out), s);
  endtask

  task automatic step(input logic c, input logic [7:0] x);
    clear = c;
    sample_in = x;
    sample_delayed = dl[7];
    @(posedge clk);
    #1;
    for (int i = 7; i > 0; i--) dl[i] = dl[i-1];
    dl[0] = x;
    if (c) win.delete();
    else begin
      win.push_back(int'(x));
      if (win.size() > 8) void'(win.pop_front());
    end
    model_check();
  endtask

  function automatic void add(input logic c, input logic [7:0] x, input int s, input int a, input logic v, input logic f);
    vec_t e;
    e.c = c; e.x = x; e.s = s; e.a = a; e.v = v; e.f = f;
    tbl.push_back(e);
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) dl[i] = '0;
    for (int i = 1; i <= 8; i++) add(1'b0, 8'd10, 10 * i, (10 * i) / 8, i == 8, i < 8);
    for (int i = 0; i < 2; i++) add(1'b0, 8'd10, 80, 10, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) add(1'b0, 8'd50, 80 + 40 * i, (80 + 40 * i) / 8, 1'b1, 1'b0);
    add(1'b0, 8'd50, 400, 50, 1'b1, 1'b0);
    add(1'b1, 8'd99, 0, 0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) add(1'b0, 8'd20, 20 * i, (20 * i) / 8, i == 8, i < 8);
    add(1'b1, 8'd77, 0, 0, 1'b0, 1'b0);
    add(1'b1, 8'd77, 0, 0, 1'b0, 1'b0);
    #12;
    chk("reset sum", int'(m0.sum_out), 0);
    chk("reset avg", int'(m0.avg_out), 0);
    chk("reset valid", int'(m0.out_valid), 0);
    chk("reset filling", int'(m0.filling), 0);
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      step(tbl[i].c, tbl[i].x);
      chk("vec sum", int'(m0.sum_out), tbl[i].s);
      chk("vec avg", int'(m0.avg_out), tbl[i].a);
      chk("vec valid", int'(m0.out_valid), int'(tbl[i].v));
      chk("vec filling", int'(m0.filling), int'(tbl[i].f));
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'd33);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst sum", int'(m0.sum_out), 0);
    chk("async rst avg", int'(m1.avg_out), 0);
    chk("async rst valid", int'(m0.out_valid), 0);
    chk("async rst filling", int'(m0.filling), 0);
    win.delete();
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 8'd7);
      chk("rst refill valid", int'(m0.out_valid), int'(i == 8));
    end
    step(1'b1, 8'd0);
    for (int i = 0; i < 9; i++) step(1'b0, 8'd255);
    chk("full sum", int'(m0.sum_out), 2040);
    chk("full avg trunc", int'(m0.avg_out), 255);
    chk("full avg round", int'(m1.avg_out), 255);
    step(1'b1, 8'd0);
    for (int i = 0; i < 7; i++) step(1'b0, 8'd0);
    step(1'b0, 8'd4);
    chk("round window sum", int'(m0.sum_out), 4);
    chk("round window trunc", int'(m0.avg_out), 0);
    chk("round window half-up", int'(m1.avg_out), 1);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 31) == 0, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
